// File: rtl/lsu_ctrl_if.sv
// ============================================================================
// Module   : lsu_ctrl_if
// Brief    : Data-memory request/grant/response bus between LSU and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lsu_ctrl_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Load/store unit: lane alignment, sign/zero extension, memory
//            handshake with timeout, core stall generation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        mem_rd,
    input  wire logic        mem_wr,
    input  wire logic [2:0]  mask,
    input  wire logic [31:0] addr_i,
    input  wire logic [31:0] wdata_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      rdata_o,
    lsu_ctrl_if.master       dmem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [29:0]       r_addr;
    logic [1:0]        r_offset;
    logic [2:0]        r_mask;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_access;
    logic              w_legal_mask;
    logic              w_misalign;
    logic              w_legal;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_timeout;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_fmt;

    assign w_access  = mem_rd | mem_wr;
    assign w_timeout = (r_cnt >= c_cnt_last);

    // Stores accept only B/H/W; loads additionally accept BU/HU.
    always_comb begin
        w_legal_mask = 1'b0;
        case (mask)
            3'b000, 3'b001, 3'b010: w_legal_mask = 1'b1;
            3'b100, 3'b101:         w_legal_mask = ~mem_wr;
            default:                w_legal_mask = 1'b0;
        endcase
    end

    assign w_misalign = ((mask[1:0] == 2'b01) && addr_i[0]) ||
                        ((mask == 3'b010) && (addr_i[1:0] != 2'b00));
    assign w_legal    = w_legal_mask & ~w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
        case (mask[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << addr_i[1:0];
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata_i;
            end
        endcase
    end

    always_comb begin
        w_byte = dmem.dmem_rdata_i[7:0];
        case (r_offset)
            2'd0:    w_byte = dmem.dmem_rdata_i[7:0];
            2'd1:    w_byte = dmem.dmem_rdata_i[15:8];
            2'd2:    w_byte = dmem.dmem_rdata_i[23:16];
            default: w_byte = dmem.dmem_rdata_i[31:24];
        endcase
        w_half = r_offset[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
        case (r_mask)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = dmem.dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        stall_o           = 1'b0;
        done_o            = 1'b0;
        err_o             = 1'b0;
        rdata_o           = 32'd0;
        dmem.dmem_req_o   = 1'b0;
        dmem.dmem_we_o    = 1'b0;
        dmem.dmem_addr_o  = 32'd0;
        dmem.dmem_be_o    = 4'd0;
        dmem.dmem_wdata_o = 32'd0;
        case (r_state)
            S_IDLE: begin
                stall_o = w_access;
                if (w_access) begin
                    w_state_nxt = w_legal ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                stall_o           = 1'b1;
                dmem.dmem_req_o   = 1'b1;
                dmem.dmem_we_o    = r_we;
                dmem.dmem_addr_o  = {r_addr, 2'b00};
                dmem.dmem_be_o    = r_be;
                dmem.dmem_wdata_o = r_wdata;
                // A grant on the timeout cycle still completes the access.
                if (dmem.dmem_gnt_i) begin
                    w_state_nxt = r_we ? S_DONE : S_WAIT;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (dmem.dmem_rvalid_i || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                done_o      = 1'b1;
                err_o       = r_err;
                rdata_o     = r_rdata;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= 30'd0;
            r_offset <= 2'd0;
            r_mask   <= 3'd0;
            r_we     <= 1'b0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_addr   <= addr_i[31:2];
                        r_offset <= addr_i[1:0];
                        r_mask   <= mask;
                        r_we     <= mem_wr;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_err    <= ~w_legal;
                        r_rdata  <= 32'd0;
                        r_cnt    <= '0;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!dmem.dmem_gnt_i && w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem.dmem_rvalid_i) begin
                        r_rdata <= w_load_fmt;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Directed scoreboard bench for lsu_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mask;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;

    int n_tests = 0;
    int n_fail  = 0;

    bus_t        exp_bus[$];
    logic [32:0] exp_resp[$];

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .mask    (mask),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .stall_o (stall_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .rdata_o (rdata_o),
        .dmem    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: bus requests checked every cycle against the head expectation,
    // popped when the request falls; responses popped on done_o.
    initial begin : mon
        logic        req_q;
        logic [32:0] r;
        req_q = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dmem_req_o) begin
                if (exp_bus.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL bus_unexpected_req: got addr %0h, required no request",
                             bus.dmem_addr_o);
                end else begin
                    chk("bus_req", {bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o,
                                    bus.dmem_wdata_o}, exp_bus[0]);
                end
            end else if (req_q && exp_bus.size() != 0) begin
                void'(exp_bus.pop_front());
            end
            req_q = bus.dmem_req_o;
            if (done_o) begin
                if (exp_resp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected_done: got err %0b rdata %0h, required no done",
                             err_o, rdata_o);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp", {err_o, rdata_o}, r);
                end
            end
        end
    end

    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                             input int gnt_dly, input int rv_dly, input logic [31:0] word,
                             input logic ex_req, input bus_t ex_bus,
                             input logic ex_err, input logic [31:0] ex_rdata,
                             input int ex_stall, input int ex_reqcyc);
        int stall_cnt = 0;
        int req_cnt   = 0;
        int wait_cnt  = 0;
        bit granted   = 1'b0;
        bit done      = 1'b0;
        if (ex_req) exp_bus.push_back(ex_bus);
        exp_resp.push_back({ex_err, ex_rdata});
        @(posedge clk);
        #1;
        mem_rd = rd; mem_wr = wr; mask = m; addr_i = a; wdata_i = wd;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            bus.dmem_gnt_i    = 1'b0;
            bus.dmem_rvalid_i = 1'b0;
            bus.dmem_rdata_i  = 32'd0;
            if (done_o) begin
                done = 1'b1;
                chk({name, "_stall_in_done"}, stall_o, 1'b0);
                mem_rd = 1'b0;
                mem_wr = 1'b0;
            end else begin
                if (stall_o) stall_cnt++;
                if (bus.dmem_req_o) begin
                    if (req_cnt == gnt_dly) begin
                        bus.dmem_gnt_i = 1'b1;
                        granted = 1'b1;
                    end
                    req_cnt++;
                end else if (granted) begin
                    if (wait_cnt == rv_dly) begin
                        bus.dmem_rvalid_i = 1'b1;
                        bus.dmem_rdata_i  = word;
                    end
                    wait_cnt++;
                end
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_no_done: got no done_o within 400 cycles, required done_o", name);
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
        chk({name, "_stall_cycles"}, stall_cnt, ex_stall);
        chk({name, "_req_cycles"}, req_cnt, ex_reqcyc);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {stall_o, done_o, err_o, rdata_o, bus.dmem_req_o, bus.dmem_we_o,
                   bus.dmem_addr_o, bus.dmem_be_o, bus.dmem_wdata_o}, 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        mem_rd = 1'b0; mem_wr = 1'b0; mask = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
        bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle_outputs");

        //         name       rd wr  mask    addr          wdata         gnt rv  word
        do_access("lb_neg",   1, 0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h8012_3456,
                  1, {1'b0, 32'h100, 4'b1000, 32'h0}, 0, 32'hFFFF_FF80, 3, 1);
        do_access("lbu",      1, 0, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 32'h8012_3456,
                  1, {1'b0, 32'h100, 4'b1000, 32'h0}, 0, 32'h0000_0080, 3, 1);
        do_access("sh",       0, 1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 0, 0, 32'h0,
                  1, {1'b1, 32'h100, 4'b1100, 32'hBEEF_BEEF}, 0, 32'h0, 2, 1);
        do_access("lw_misal", 1, 0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h0,
                  0, '0, 1, 32'h0, 1, 0);
        do_access("lh_slow",  1, 0, 3'b001, 32'h0000_0200, 32'h0, 3, 2, 32'h0000_7FFF,
                  1, {1'b0, 32'h200, 4'b0011, 32'h0}, 0, 32'h0000_7FFF, 8, 4);
        do_access("timeout",  1, 0, 3'b010, 32'h0000_0400, 32'h0, -1, 0, 32'h0,
                  1, {1'b0, 32'h400, 4'b1111, 32'h0}, 1, 32'h0, 256, 255);
        do_access("gnt_last", 1, 0, 3'b010, 32'h0000_0400, 32'h0, 254, 0, 32'h1122_3344,
                  1, {1'b0, 32'h400, 4'b1111, 32'h0}, 0, 32'h1122_3344, 257, 255);
        do_access("sb",       0, 1, 3'b000, 32'h0000_0011, 32'h1234_5678, 0, 0, 32'h0,
                  1, {1'b1, 32'h10, 4'b0010, 32'h7878_7878}, 0, 32'h0, 2, 1);
        do_access("sw_both",  1, 1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 0, 0, 32'h0,
                  1, {1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D}, 0, 32'h0, 2, 1);
        do_access("lhu",      1, 0, 3'b101, 32'h0000_0006, 32'h0, 0, 0, 32'h8001_0000,
                  1, {1'b0, 32'h4, 4'b1100, 32'h0}, 0, 32'h0000_8001, 3, 1);
        do_access("lh_neg",   1, 0, 3'b001, 32'h0000_0006, 32'h0, 0, 0, 32'h8001_0000,
                  1, {1'b0, 32'h4, 4'b1100, 32'h0}, 0, 32'hFFFF_8001, 3, 1);
        do_access("lb_pos",   1, 0, 3'b000, 32'h0000_0001, 32'h0, 0, 0, 32'h0000_7F00,
                  1, {1'b0, 32'h0, 4'b0010, 32'h0}, 0, 32'h0000_007F, 3, 1);
        do_access("sbu_ill",  0, 1, 3'b100, 32'h0000_0008, 32'h55, 0, 0, 32'h0,
                  0, '0, 1, 32'h0, 1, 0);
        do_access("lw_rv1",   1, 0, 3'b010, 32'h0000_0044, 32'h0, 0, 1, 32'hDEAD_BEEF,
                  1, {1'b0, 32'h44, 4'b1111, 32'h0}, 0, 32'hDEAD_BEEF, 4, 1);

        // Reset during WAIT: the late response must be ignored.
        exp_bus.push_back({1'b0, 32'h300, 4'b1111, 32'h0});
        @(posedge clk);
        #1;
        mem_rd = 1'b1; mask = 3'b010; addr_i = 32'h0000_0300; wdata_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_seen", bus.dmem_req_o, 1'b1);
        bus.dmem_gnt_i = 1'b1;
        @(negedge clk);
        bus.dmem_gnt_i = 1'b0;
        chk("rst_in_wait_stall", stall_o, 1'b1);
        #1;
        rst = 1'b1;
        mem_rd = 1'b0;
        #1;
        chk_all_zero("rst_async_outputs");
        @(negedge clk);
        rst = 1'b0;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_all_zero("rst_late_rvalid");
        end
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = 32'd0;

        repeat (3) @(negedge clk);
        chk("exp_bus_drained", exp_bus.size(), 0);
        chk("exp_resp_drained", exp_resp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly downstream of the main decoder. It consumes mem_rd, mem_wr and mask (funct3), plus the ALU-computed address and the rs2 data.
- Runs a request/grant/response handshake with the data memory, handles byte-lane alignment and sign or zero extension, and stalls the core until the access completes.
- Its formatted load data feeds the write-back mux (sel_wb = 0 path).

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ+WAIT before the access is abandoned with error.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  Core clock.
- rst  in  1  Reset, asynchronous, active-high.
- mem_rd  in  1  Load request from decoder.
- mem_wr  in  1  Store request from decoder.
- mask  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  Byte address (ALU result).
- wdata_i  in  32  Store data (rs2).
- stall_o  out  1  Hold PC/pipeline while high.
- done_o  out  1  One-cycle pulse: access finished (success or error).
- err_o  out  1  Valid with done_o: misaligned, illegal mask or timeout.
- rdata_o  out  32  Formatted load data; valid while done_o is high.
- dmem_req_o  out  1  Memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  Word address, {addr_i[31:2], 2'b00}.
- dmem_be_o  out  4  Byte enables.
- dmem_wdata_o  out  32  Lane-replicated store data.
- dmem_gnt_i  in  1  Request accepted this cycle.
- dmem_rvalid_i  in  1  Read data valid.
- dmem_rdata_i  in  32  Read data word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (async) or IDLE: dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, done_o=0, err_o=0, rdata_o=0, timeout counter=0.
- IDLE, access detected (mem_rd or mem_wr high; if both are high, store wins):
  - Register addr, offset = addr_i[1:0], mask, we, the be pattern and the replicated wdata.
  - Legal access -> REQ.
  - Illegal access -> DONE with err=1 and no bus request. Illegal means: mask not in the legal set (stores accept only 000/001/010); H/HU with addr[0]=1; W with addr[1:0]!=0.
- stall_o = (IDLE & (mem_rd | mem_wr)) | REQ | WAIT. Combinational; low in DONE.
- Store lane rules:
  - SB: wdata = {4{wdata_i[7:0]}}, be = 4'b0001 << offset.
  - SH: wdata = {2{wdata_i[15:0]}}, be = 4'b0011 << offset.
  - SW: wdata = wdata_i, be = 4'b1111.
- Loads drive be using the same pattern as the matching store width, with we=0.
- REQ:
  - req=1; addr, we, be and wdata held stable until gnt is sampled high.
  - On gnt: store -> DONE; load -> WAIT, with req dropped the next cycle.
- WAIT:
  - req=0; dmem_rvalid_i is sampled only in this state.
  - On rvalid: select the lane by offset, sign-extend for B/H or zero-extend for BU/HU, register into rdata, -> DONE.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES -> DONE with err=1, rdata=0, req dropped.
  - A gnt or rvalid arriving on the same cycle as the timeout wins over the timeout.
- DONE: exactly one cycle; done_o=1, err_o as determined; -> IDLE unconditionally. A request still visible in the same cycle is not re-accepted, because the core advances at the edge ending DONE.
- Latency, zero-wait memory:
  - Store: stall for 2 cycles (IDLE, REQ), done_o in the 3rd.
  - Load with rvalid the cycle after gnt: stall 3, done_o in the 4th.
- Reset asserted mid-access: immediate return to IDLE, req deasserted asynchronously, in-flight response ignored.
- Error accesses never drive dmem_req_o.

Test Plan:
- LB at addr 0x0000_0103, memory word 0x8012_3456 -> dmem_addr 0x100, be 4'b1000, rdata_o 0xFFFF_FF80; LBU at the same address -> 0x0000_0080; err_o=0.
- SH at addr 0x0000_0102, wdata_i 0x0000_BEEF, gnt on first REQ cycle -> dmem_we=1, be 4'b1100, dmem_wdata 0xBEEF_BEEF; stall_o high 2 cycles, then done_o pulse.
- LW at addr 0x0000_0101 -> no dmem_req_o ever; done_o and err_o pulse in the cycle after detection; stall_o high for 1 cycle.
- LH at 0x200 with gnt withheld 3 cycles, then rvalid 2 cycles later carrying 0x0000_7FFF -> req held with stable addr for 4 cycles, rdata_o 0x0000_7FFF, stall_o covers every cycle until DONE.
- gnt never asserted, TIMEOUT_CYCLES=255 -> req drops and done_o+err_o pulse exactly 255 cycles after REQ entry; rdata_o=0.
- rst pulsed during WAIT, then rvalid arrives -> FSM in IDLE, all outputs 0, no done_o, the late rvalid is ignored.
